int_res_mem_ctrl: RTL and testbench

- Responder (memory-controller) end of the intermediate-result memory interface: accepts read/write requests from compute, drives one single-port SRAM bank.
- Converts between the requester's fixed-point format and the fixed storage format (single width only).
- Splits double-width accesses into two sequential bank word accesses.
- Sits between the compute FSM and the int-res bank macro.

---
 rtl/int_res_mem_ctrl_pkg.sv | 35 +++
 rtl/int_res_mem_ctrl_fx_shift_sat.sv | 32 +++
 rtl/int_res_mem_ctrl.sv | 163 ++++++++++++++++
 tb/tb_int_res_mem_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/int_res_mem_ctrl_pkg.sv
// Shared types and helpers for the intermediate-result memory controller.
// Storage format, width encoding, FSM states and the saturation helper.
package int_res_mem_ctrl_pkg;

  typedef enum logic {
    SINGLE = 1'b0,
    DOUBLE = 1'b1
  } DataWidth_t;

  typedef logic [3:0] FxFormatIntRes_t;

  localparam int STORE_FRAC = 10;

  typedef enum logic [2:0] {
    IDLE,
    WR_HI,
    RD_LO_WAIT,
    RD_HI,
    RD_HI_WAIT
  } state_t;

  function automatic logic signed [63:0] sat_word(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/int_res_mem_ctrl_fx_shift_sat.sv
// Fixed-point re-scale: shift by a signed amount, round half up,
// saturate to a signed word.
module fx_shift_sat
  import int_res_mem_ctrl_pkg::*;
#(
  parameter int WORD_W = 16
) (
  input  logic [WORD_W-1:0] x,
  input  logic signed [5:0] shamt,
  output logic [WORD_W-1:0] y
);

  logic signed [63:0] xs;
  logic signed [63:0] v;
  logic signed [63:0] s;
  logic [5:0]         mag;

  always_comb begin
    xs  = {{(64-WORD_W){x[WORD_W-1]}}, x};
    mag = shamt[5] ? 6'(-shamt) : shamt;
    v   = xs;
    if (shamt > 0) begin
      v = xs <<< mag;
    end else if (shamt < 0) begin
      // bias by half an LSB of the result before truncating
      v = (xs + (64'sd1 <<< (mag - 6'd1))) >>> mag;
    end
    s = sat_word(v, WORD_W);
    y = s[WORD_W-1:0];
  end

endmodule

// File: rtl/int_res_mem_ctrl.sv
// Responder side of the int-res memory interface: format conversion,
// double-width splitting and single-port bank sequencing.
module int_res_mem_ctrl #(
  parameter int ADDR_W     = 12,
  parameter int WORD_W     = 16,
  parameter int STORE_FRAC = int_res_mem_ctrl_pkg::STORE_FRAC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [2*WORD_W-1:0] wr_data,
  input  logic                wr_width,
  input  logic [3:0]          wr_format,
  output logic                wr_ready,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  input  logic                rd_width,
  input  logic [3:0]          rd_format,
  output logic                rd_ready,
  output logic [2*WORD_W-1:0] rd_data,
  output logic                rd_valid,
  output logic                bank_en,
  output logic                bank_we,
  output logic [ADDR_W-1:0]   bank_addr,
  output logic [WORD_W-1:0]   bank_wdata,
  input  logic [WORD_W-1:0]   bank_rdata,
  output logic                addr_err
);
  import int_res_mem_ctrl_pkg::*;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] hi_q;
  logic [WORD_W-1:0] lo_q;
  FxFormatIntRes_t   fmt_q;
  logic [WORD_W-1:0] conv_w;
  logic [WORD_W-1:0] conv_r;
  logic signed [5:0] sh_w;
  logic signed [5:0] sh_r;
  logic              wr_dbl;
  logic              rd_dbl;
  logic              wr_go;
  logic              rd_go;
  logic              wrap;

  assign wr_dbl = DataWidth_t'(wr_width) == DOUBLE;
  assign rd_dbl = DataWidth_t'(rd_width) == DOUBLE;
  assign wr_go  = (state_q == IDLE) && wr_en;
  assign rd_go  = (state_q == IDLE) && !wr_en && rd_en;
  assign wrap   = (wr_go && wr_dbl && (&wr_addr)) ||
                  (rd_go && rd_dbl && (&rd_addr));

  assign sh_w = 6'(STORE_FRAC) - 6'(wr_format);
  assign sh_r = 6'(fmt_q) - 6'(STORE_FRAC);

  fx_shift_sat #(.WORD_W(WORD_W)) u_conv_w (
    .x     (wr_data[WORD_W-1:0]),
    .shamt (sh_w),
    .y     (conv_w)
  );

  fx_shift_sat #(.WORD_W(WORD_W)) u_conv_r (
    .x     (bank_rdata),
    .shamt (sh_r),
    .y     (conv_r)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (wr_en)      state_d = wr_dbl ? WR_HI : IDLE;
        else if (rd_en) state_d = rd_dbl ? RD_HI : RD_LO_WAIT;
      end
      WR_HI:      state_d = IDLE;
      RD_LO_WAIT: state_d = IDLE;
      RD_HI:      state_d = RD_HI_WAIT;
      RD_HI_WAIT: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // bank side is gated by rst_n so it drops the moment reset asserts
  always_comb begin
    wr_ready   = 1'b0;
    rd_ready   = 1'b0;
    bank_en    = 1'b0;
    bank_we    = 1'b0;
    bank_addr  = '0;
    bank_wdata = '0;
    if (rst_n) begin
      unique case (state_q)
        IDLE: begin
          wr_ready = 1'b1;
          rd_ready = !wr_en;
          if (wr_en) begin
            bank_en    = 1'b1;
            bank_we    = 1'b1;
            bank_addr  = wr_addr;
            bank_wdata = wr_dbl ? wr_data[WORD_W-1:0] : conv_w;
          end else if (rd_en) begin
            bank_en   = 1'b1;
            bank_addr = rd_addr;
          end
        end
        WR_HI: begin
          bank_en    = 1'b1;
          bank_we    = 1'b1;
          bank_addr  = addr_q;
          bank_wdata = hi_q;
        end
        RD_HI: begin
          bank_en   = 1'b1;
          bank_addr = addr_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      fmt_q    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (wrap) addr_err <= 1'b1;
      unique case (1'b1)
        wr_go: begin
          addr_q <= wr_addr + 1'b1;
          hi_q   <= wr_data[2*WORD_W-1:WORD_W];
        end
        rd_go: begin
          addr_q <= rd_addr + 1'b1;
          fmt_q  <= rd_format;
        end
        state_q == RD_LO_WAIT: begin
          rd_data  <= {{WORD_W{conv_r[WORD_W-1]}}, conv_r};
          rd_valid <= 1'b1;
        end
        state_q == RD_HI: lo_q <= bank_rdata;
        state_q == RD_HI_WAIT: begin
          rd_data  <= {bank_rdata, lo_q};
          rd_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_int_res_mem_ctrl.sv
// Scoreboard bench for int_res_mem_ctrl with a behavioural SRAM bank.
// Reads push expected data and arrival cycle; a monitor checks rd_valid.
module tb_int_res_mem_ctrl;
  import int_res_mem_ctrl_pkg::*;

  localparam int AW = 12;
  localparam int WW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [31:0]   wr_data = '0;
  logic          wr_width = 1'b0;
  logic [3:0]    wr_format = '0;
  logic          wr_ready;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_width = 1'b0;
  logic [3:0]    rd_format = '0;
  logic          rd_ready;
  logic [31:0]   rd_data;
  logic          rd_valid;
  logic          bank_en;
  logic          bank_we;
  logic [AW-1:0] bank_addr;
  logic [WW-1:0] bank_wdata;
  logic [WW-1:0] bank_rdata = '0;
  logic          addr_err;

  int_res_mem_ctrl u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_width   (wr_width),
    .wr_format  (wr_format),
    .wr_ready   (wr_ready),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_width   (rd_width),
    .rd_format  (rd_format),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .bank_en    (bank_en),
    .bank_we    (bank_we),
    .bank_addr  (bank_addr),
    .bank_wdata (bank_wdata),
    .bank_rdata (bank_rdata),
    .addr_err   (addr_err)
  );

  always #5 clk = ~clk;

  logic [WW-1:0] mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

  always @(posedge clk) begin
    if (bank_en && bank_we) mem[bank_addr] <= bank_wdata;
    else if (bank_en)       bank_rdata <= mem[bank_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t x;
    if (rd_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rd_valid", 32'(rd_valid), 32'd0);
      end else begin
        x = sb.pop_front();
        chk({x.name, "_data"}, rd_data, x.data);
        chk({x.name, "_cycle"}, 32'(cyc), 32'(x.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d,
                          input logic w, input logic [3:0] f);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_width = w; wr_format = f;
    @(negedge clk);
    chk("wr_ready_accept", 32'(wr_ready), 32'd1);
    tick();
    wr_en = 1'b0; wr_data = '0;
    if (w) begin
      @(negedge clk);
      chk("wr_ready_busy", 32'(wr_ready), 32'd0);
      tick();
    end
  endtask

  task automatic wait_drain(input string nm);
    int k = 0;
    while (sb.size() != 0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_drain"}, 32'(sb.size()), 32'd0);
    tick();
  endtask

  task automatic push_exp(input logic [31:0] e, input int c, input string nm);
    exp_t x;
    x.data = e; x.cyc = c; x.name = nm;
    sb.push_back(x);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic w,
                         input logic [3:0] f, input logic [31:0] e,
                         input string nm);
    rd_en = 1'b1; rd_addr = a; rd_width = w; rd_format = f;
    push_exp(e, cyc + (w ? 3 : 2), nm);
    @(negedge clk);
    chk({nm, "_rd_ready"}, 32'(rd_ready), 32'd1);
    tick();
    rd_en = 1'b0;
    wait_drain(nm);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_rd_ready", 32'(rd_ready), 32'd0);
    chk("rst_bank_en", 32'(bank_en), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_wr_ready", 32'(wr_ready), 32'd1);
    chk("idle_rd_ready", 32'(rd_ready), 32'd1);
    tick();

    do_write(12'd5, 32'h0000_0100, SINGLE, 4'd8);
    chk("mem5", 32'(mem[5]), 32'h0400);
    do_read(12'd5, SINGLE, 4'd8, 32'h0000_0100, "rd_single");

    do_write(12'd10, 32'hDEAD_BEEF, DOUBLE, 4'd0);
    @(negedge clk);
    chk("wr_ready_back", 32'(wr_ready), 32'd1);
    chk("mem10", 32'(mem[10]), 32'hBEEF);
    chk("mem11", 32'(mem[11]), 32'hDEAD);
    tick();
    do_read(12'd10, DOUBLE, 4'd0, 32'hDEAD_BEEF, "rd_double");

    do_write(12'd20, 32'h0000_7000, SINGLE, 4'd4);
    chk("mem20_sat", 32'(mem[20]), 32'h7FFF);
    do_read(12'd20, SINGLE, 4'd4, 32'h0000_0200, "rd_sat");

    do_write(12'd21, 32'h0000_0003, SINGLE, 4'd12);
    chk("mem21_round", 32'(mem[21]), 32'h0001);
    do_read(12'd21, SINGLE, 4'd12, 32'h0000_0004, "rd_round");

    do_write(12'd22, 32'h0000_FF00, SINGLE, 4'd8);
    chk("mem22_neg", 32'(mem[22]), 32'hFC00);
    do_read(12'd22, SINGLE, 4'd8, 32'hFFFF_FF00, "rd_neg");

    wr_en = 1'b1; wr_addr = 12'd30; wr_data = 32'h5;
    wr_width = SINGLE; wr_format = 4'd10;
    rd_en = 1'b1; rd_addr = 12'd5; rd_width = SINGLE; rd_format = 4'd8;
    @(negedge clk);
    chk("both_rd_ready", 32'(rd_ready), 32'd0);
    chk("both_wr_ready", 32'(wr_ready), 32'd1);
    tick();
    wr_en = 1'b0;
    push_exp(32'h0000_0100, cyc + 2, "rd_held");
    @(negedge clk);
    chk("held_rd_ready", 32'(rd_ready), 32'd1);
    chk("mem30", 32'(mem[30]), 32'h0005);
    tick();
    rd_en = 1'b0;
    wait_drain("rd_held");

    do_write(12'hFFF, 32'h0000_1234, SINGLE, 4'd10);
    do_write(12'h000, 32'h0000_ABCD, SINGLE, 4'd10);
    chk("addr_err_pre", 32'(addr_err), 32'd0);
    do_read(12'hFFF, DOUBLE, 4'd0, 32'hABCD_1234, "rd_wrap");
    chk("addr_err_set", 32'(addr_err), 32'd1);
    do_write(12'd40, 32'h0000_0400, SINGLE, 4'd10);
    do_read(12'd40, SINGLE, 4'd10, 32'h0000_0400, "rd_after_wrap");
    chk("addr_err_sticky", 32'(addr_err), 32'd1);

    rd_en = 1'b1; rd_addr = 12'd10; rd_width = DOUBLE; rd_format = 4'd0;
    tick();
    rd_en = 1'b0;
    chk("rdhi_bank_en", 32'(bank_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bank_en", 32'(bank_en), 32'd0);
    chk("mid_rst_bank_addr", 32'(bank_addr), 32'd0);
    chk("mid_rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_addr_err", 32'(addr_err), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("post_rst_rd_data", rd_data, 32'd0);
    repeat (4) tick();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
